// File: rtl/ddr3_model_pkg.sv
// ddr3_model_pkg: shared command/error/bank types, latency limits and mode-register decode
package ddr3_model_pkg;
    localparam int CL_MAX = 11;
    localparam int CWL_MAX = 12;
    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_NOP = 3'b111
    } cmd_e;
    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_IDLE_BANK = 3'd1,
        ERR_BANK_OPEN = 3'd2,
        ERR_TRCD      = 3'd3,
        ERR_SLOT      = 3'd4,
        ERR_BUSY      = 3'd5,
        ERR_RSVD_CL   = 3'd6
    } err_e;
    typedef enum logic {
        BANK_IDLE,
        BANK_ACTIVE
    } bank_e;
    // MR0 CAS latency field value 0 has no legal encoding
    function automatic logic mr0_reserved(input logic [2:0] f);
        return f == 3'd0;
    endfunction
    function automatic logic [3:0] mr0_cl(input logic [2:0] f);
        return {1'b0, f} + 4'd4;
    endfunction
    function automatic logic [3:0] mr2_cwl(input logic [2:0] f);
        return {1'b0, f} + 4'd5;
    endfunction
endpackage

// File: rtl/ddr3_burst_slots.sv
// ddr3_burst_slots: per-cycle beat schedule that shifts toward the head, claims BL slots at a latency and flags overlap
module ddr3_burst_slots #(
    parameter int D  = 19,
    parameter int AW = 12,
    parameter int BL = 8,
    parameter int LW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          claim_i,
    input  logic [LW-1:0] lat_i,
    input  logic [AW-1:0] base_i,
    output logic          conflict_o,
    output logic          head_v_o,
    output logic [AW-1:0] head_addr_o
);
    logic [D-1:0]         v_q, v_d, hit;
    logic [D-1:0][AW-1:0] a_q, a_d;

    // Slot j after the shift is consumed lat+offset edges from now; a claimed beat wraps inside its 8-column block
    always_comb begin
        v_d = v_q >> 1;
        a_d = a_q >> AW;
        hit = '0;
        for (int j = 0; j < D; j++) begin
            hit[j] = (j + 1 >= int'(lat_i)) && (j + 1 < int'(lat_i) + BL);
            if (claim_i && hit[j]) begin
                v_d[j] = 1'b1;
                a_d[j] = {base_i[AW-1:3], base_i[2:0] + 3'(j + 1 - int'(lat_i))};
            end
        end
    end

    assign conflict_o  = |(hit & (v_q >> 1));
    assign head_v_o    = v_q[0];
    assign head_addr_o = a_q[0];

    // Schedule register; reset abandons every pending beat
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q <= '0;
            a_q <= '0;
        end else begin
            v_q <= v_d;
            a_q <= a_d;
        end
    end
endmodule

// File: rtl/ddr3_cycle_model.sv
// ddr3_cycle_model: cycle-level DDR3 memory with bank tracking, CL/CWL pipelines and one-cycle error reporting
module ddr3_cycle_model
    import ddr3_model_pkg::*;
#(
    parameter int MEM_ROW_ADDR_WIDTH = 15,
    parameter int MEM_COL_ADDR_WIDTH = 10,
    parameter int MEM_BADDR_WIDTH    = 3,
    parameter int MEM_DQS_WIDTH      = 4,
    parameter int MEM_DQ_WIDTH       = 8 * MEM_DQS_WIDTH,
    parameter int MEM_DM_WIDTH       = MEM_DQS_WIDTH,
    parameter int STORE_AW           = 12,
    parameter int BL                 = 8,
    parameter int T_RCD              = 6,
    parameter int CL_DEFAULT         = 6,
    parameter int CWL_DEFAULT        = 5
) (
    input  logic                          mem_ck,
    input  logic                          mem_rst,
    input  logic                          mem_cke,
    input  logic                          mem_cs_n,
    input  logic                          mem_ras_n,
    input  logic                          mem_cas_n,
    input  logic                          mem_we_n,
    input  logic [MEM_ROW_ADDR_WIDTH-1:0] mem_a,
    input  logic [MEM_BADDR_WIDTH-1:0]    mem_ba,
    input  logic [MEM_DQ_WIDTH-1:0]       wr_dq,
    input  logic [MEM_DM_WIDTH-1:0]       mem_dm,
    output logic [MEM_DQ_WIDTH-1:0]       rd_dq,
    output logic                          rd_valid,
    output logic                          err_valid,
    output logic [2:0]                    err_code
);
    localparam int NB = 1 << MEM_BADDR_WIDTH;
    localparam int TW = $clog2(T_RCD + 1);

    logic [2:0]                    rcw;
    cmd_e                          cmd;
    err_e                          err;
    logic                          any_act, bank_act, trcd_ok, slot_conf, rd_claim, wr_claim;
    logic [MEM_COL_ADDR_WIDTH-1:0] col;
    logic [STORE_AW-1:0]           base, rd_ha, wr_ha;
    logic                          rd_conf, wr_conf, rd_hv, wr_hv;
    bank_e                         bank_q [NB];
    bank_e                         bank_d [NB];
    logic [MEM_ROW_ADDR_WIDTH-1:0] row_q [NB];
    logic [MEM_ROW_ADDR_WIDTH-1:0] row_d [NB];
    logic [TW-1:0]                 trcd_q [NB];
    logic [TW-1:0]                 trcd_d [NB];
    logic [3:0]                    cl_q, cl_d, cwl_q, cwl_d;
    logic [MEM_DQ_WIDTH-1:0]       mem_q [2**STORE_AW];
    logic [MEM_DQ_WIDTH-1:0]       rd_dq_q;
    logic                          rd_valid_q, err_valid_q;
    logic [2:0]                    err_code_q;

    assign rcw       = {mem_ras_n, mem_cas_n, mem_we_n};
    assign cmd       = (mem_cke && !mem_cs_n && rcw != 3'b110) ? cmd_e'(rcw) : CMD_NOP;
    assign col       = mem_a[MEM_COL_ADDR_WIDTH-1:0] & ~MEM_COL_ADDR_WIDTH'(1 << 10);
    assign base      = STORE_AW'({mem_ba, row_q[mem_ba], col});
    assign bank_act  = bank_q[mem_ba] == BANK_ACTIVE;
    assign trcd_ok   = trcd_q[mem_ba] >= TW'(T_RCD - 1);
    assign slot_conf = (cmd == CMD_RD) ? rd_conf : wr_conf;
    assign rd_claim  = cmd == CMD_RD && err == ERR_NONE;
    assign wr_claim  = cmd == CMD_WR && err == ERR_NONE;

    // Any open bank blocks REF and MRS
    always_comb begin
        any_act = 1'b0;
        for (int b = 0; b < NB; b++) any_act = any_act | (bank_q[b] == BANK_ACTIVE);
    end

    // Legality of the sampled command; the chain order makes the lowest applicable code win
    always_comb begin
        err = (cmd == CMD_RD || cmd == CMD_WR) ? (!bank_act ? ERR_IDLE_BANK : !trcd_ok ? ERR_TRCD : slot_conf ? ERR_SLOT : ERR_NONE)
            : (cmd == CMD_ACT) ? (bank_act ? ERR_BANK_OPEN : ERR_NONE)
            : (cmd == CMD_REF || cmd == CMD_MRS) ? (any_act ? ERR_BUSY
                : (cmd == CMD_MRS && mem_ba == '0 && mr0_reserved(mem_a[6:4])) ? ERR_RSVD_CL : ERR_NONE)
            : ERR_NONE;
    end

    // Bank open/close and tRCD counters; only accepted commands change state
    always_comb begin
        bank_d = bank_q;
        row_d  = row_q;
        trcd_d = trcd_q;
        for (int b = 0; b < NB; b++) trcd_d[b] = (trcd_q[b] >= TW'(T_RCD - 1)) ? trcd_q[b] : trcd_q[b] + 1'b1;
        if (cmd == CMD_ACT && err == ERR_NONE) begin
            bank_d[mem_ba] = BANK_ACTIVE;
            row_d[mem_ba]  = mem_a;
            trcd_d[mem_ba] = '0;
        end
        if (cmd == CMD_PRE) begin
            for (int b = 0; b < NB; b++) if (mem_a[10] || MEM_BADDR_WIDTH'(b) == mem_ba) bank_d[b] = BANK_IDLE;
        end
        if ((rd_claim || wr_claim) && mem_a[10]) bank_d[mem_ba] = BANK_IDLE;
    end

    // Mode registers: a new latency only affects commands sampled after this edge
    always_comb begin
        cl_d  = cl_q;
        cwl_d = cwl_q;
        if (cmd == CMD_MRS && err == ERR_NONE) begin
            if (mem_ba == MEM_BADDR_WIDTH'(0)) cl_d = mr0_cl(mem_a[6:4]);
            if (mem_ba == MEM_BADDR_WIDTH'(2)) cwl_d = mr2_cwl(mem_a[5:3]);
        end
    end

    // Bank, counter and latency state
    always_ff @(posedge mem_ck) begin
        if (mem_rst) begin
            for (int b = 0; b < NB; b++) begin
                bank_q[b] <= BANK_IDLE;
                row_q[b]  <= '0;
                trcd_q[b] <= '0;
            end
            cl_q  <= 4'(CL_DEFAULT);
            cwl_q <= 4'(CWL_DEFAULT);
        end else begin
            bank_q <= bank_d;
            row_q  <= row_d;
            trcd_q <= trcd_d;
            cl_q   <= cl_d;
            cwl_q  <= cwl_d;
        end
    end

    ddr3_burst_slots #(.D(CL_MAX + BL), .AW(STORE_AW), .BL(BL), .LW(4)) u_rd_slots (
        .clk_i       (mem_ck),
        .rst_i       (mem_rst),
        .claim_i     (rd_claim),
        .lat_i       (cl_q),
        .base_i      (base),
        .conflict_o  (rd_conf),
        .head_v_o    (rd_hv),
        .head_addr_o (rd_ha)
    );

    ddr3_burst_slots #(.D(CWL_MAX + BL), .AW(STORE_AW), .BL(BL), .LW(4)) u_wr_slots (
        .clk_i       (mem_ck),
        .rst_i       (mem_rst),
        .claim_i     (wr_claim),
        .lat_i       (cwl_q),
        .base_i      (base),
        .conflict_o  (wr_conf),
        .head_v_o    (wr_hv),
        .head_addr_o (wr_ha)
    );

    // Byte-masked commit of the write beat due at this edge; storage is kept across reset
    always_ff @(posedge mem_ck) begin
        if (!mem_rst && wr_hv) begin
            for (int l = 0; l < MEM_DQS_WIDTH; l++) begin
                if (!mem_dm[l]) mem_q[wr_ha][8*l +: 8] <= wr_dq[8*l +: 8];
            end
        end
    end

    // Registered read beat (sees only writes from earlier edges) and one-cycle error pulse
    always_ff @(posedge mem_ck) begin
        if (mem_rst) begin
            rd_dq_q     <= '0;
            rd_valid_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 3'd0;
        end else begin
            rd_dq_q     <= rd_hv ? mem_q[rd_ha] : '0;
            rd_valid_q  <= rd_hv;
            err_valid_q <= err != ERR_NONE;
            err_code_q  <= err;
        end
    end

    assign rd_dq     = rd_dq_q;
    assign rd_valid  = rd_valid_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
endmodule

// File: tb/tb_ddr3_cycle_model.sv
// tb_ddr3_cycle_model: directed and random command streams checked against a cycle-indexed transaction model
module tb_ddr3_cycle_model;
    localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
    localparam logic [2:0] C_WR = 3'b100, C_RD = 3'b101, C_NOP = 3'b111;

    logic        mem_ck = 1'b0;
    logic        mem_rst = 1'b1;
    logic        mem_cke = 1'b1;
    logic        mem_cs_n = 1'b1;
    logic        mem_ras_n = 1'b1;
    logic        mem_cas_n = 1'b1;
    logic        mem_we_n = 1'b1;
    logic [14:0] mem_a = '0;
    logic [2:0]  mem_ba = '0;
    logic [31:0] wr_dq = '0;
    logic [3:0]  mem_dm = '0;
    logic [31:0] rd_dq;
    logic        rd_valid, err_valid;
    logic [2:0]  err_code;

    ddr3_cycle_model dut (
        .mem_ck    (mem_ck),
        .mem_rst   (mem_rst),
        .mem_cke   (mem_cke),
        .mem_cs_n  (mem_cs_n),
        .mem_ras_n (mem_ras_n),
        .mem_cas_n (mem_cas_n),
        .mem_we_n  (mem_we_n),
        .mem_a     (mem_a),
        .mem_ba    (mem_ba),
        .wr_dq     (wr_dq),
        .mem_dm    (mem_dm),
        .rd_dq     (rd_dq),
        .rd_valid  (rd_valid),
        .err_valid (err_valid),
        .err_code  (err_code)
    );

    always #5 mem_ck = ~mem_ck;

    typedef struct packed {
        int          a;
        logic [31:0] d;
        logic [3:0]  m;
    } wbeat_t;

    int          tests = 0;
    int          fails = 0;
    int          n = 0;
    bit          bank_open [8];
    int          bank_row [8];
    int          act_cyc [8];
    int          cl = 6;
    int          cwl = 5;
    int          rd_sched [int];
    wbeat_t      wr_sched [int];
    logic [31:0] mdl [int];
    int          wmode = 0;
    logic [31:0] wconst = '0;
    logic [3:0]  wdm0 = '0;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s @edge %0d observed=%h expected=%h", tag, n, o, e);
        end
    endtask

    task automatic step(input logic [2:0] c, input int ba, input int a, input logic rst);
        int code, lat, base, col, ad;
        logic xv, xk, any;
        logic [31:0] xd, tmp;
        wbeat_t w;
        mem_rst = rst;
        mem_cs_n = (c == C_NOP);
        {mem_ras_n, mem_cas_n, mem_we_n} = c;
        mem_ba = 3'(ba);
        mem_a = 15'(a);
        if (wr_sched.exists(n)) begin
            wr_dq = wr_sched[n].d;
            mem_dm = wr_sched[n].m;
        end else begin
            wr_dq = $urandom;
            mem_dm = 4'($urandom);
        end
        @(posedge mem_ck);
        code = 0; xv = 0; xk = 0; xd = '0; any = 0;
        col = a % 1024;
        if (rst) begin
            rd_sched.delete();
            wr_sched.delete();
            foreach (bank_open[b]) bank_open[b] = 0;
            cl = 6;
            cwl = 5;
        end else begin
            if (rd_sched.exists(n)) begin
                xv = 1;
                xk = mdl.exists(rd_sched[n]);
                if (xk) xd = mdl[rd_sched[n]];
                rd_sched.delete(n);
            end
            if (wr_sched.exists(n)) begin
                w = wr_sched[n];
                if (mdl.exists(w.a)) begin
                    tmp = mdl[w.a];
                    for (int l = 0; l < 4; l++) if (!w.m[l]) tmp[8*l +: 8] = w.d[8*l +: 8];
                    mdl[w.a] = tmp;
                end else if (w.m == 4'h0) mdl[w.a] = w.d;
                wr_sched.delete(n);
            end
            foreach (bank_open[b]) any |= bank_open[b];
            lat = (c == C_RD) ? cl : cwl;
            case (c)
                C_ACT: code = bank_open[ba] ? 2 : 0;
                C_RD, C_WR: begin
                    if (!bank_open[ba]) code = 1;
                    else if (n - act_cyc[ba] < 6) code = 3;
                    else for (int i = 0; i < 8; i++)
                        if ((c == C_RD) ? rd_sched.exists(n + lat + i) : wr_sched.exists(n + lat + i)) code = 4;
                end
                C_REF: code = any ? 5 : 0;
                C_MRS: code = any ? 5 : (ba == 0 && ((a >> 4) & 7) == 0) ? 6 : 0;
                default: code = 0;
            endcase
            if (code == 0) begin
                case (c)
                    C_ACT: begin
                        bank_open[ba] = 1;
                        bank_row[ba] = a;
                        act_cyc[ba] = n;
                    end
                    C_PRE: begin
                        if (a & 1024) foreach (bank_open[b]) bank_open[b] = 0;
                        else bank_open[ba] = 0;
                    end
                    C_RD, C_WR: begin
                        base = ((ba * 32768 + bank_row[ba]) * 1024 + col) % 4096;
                        for (int i = 0; i < 8; i++) begin
                            ad = (base / 8) * 8 + (col + i) % 8;
                            if (c == C_RD) rd_sched[n + cl + i] = ad;
                            else begin
                                w.a = ad;
                                w.d = (wmode == 0) ? 32'(32'h11111111 * (i + 1)) : (wmode == 1) ? wconst : $urandom;
                                w.m = (wmode == 2) ? (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0) : (i == 0 ? wdm0 : 4'h0);
                                wr_sched[n + cwl + i] = w;
                            end
                        end
                        if (a & 1024) bank_open[ba] = 0;
                    end
                    C_MRS: begin
                        if (ba == 0) cl = ((a >> 4) & 7) + 4;
                        if (ba == 2) cwl = ((a >> 3) & 7) + 5;
                    end
                    default: ;
                endcase
            end
        end
        #1;
        check("rd_valid", 32'(rd_valid), 32'(xv));
        if (xv && xk) check("rd_dq", rd_dq, xd);
        check("err_valid", 32'(err_valid), 32'(code != 0));
        if (code != 0) check("err_code", 32'(err_code), 32'(code));
        n++;
    endtask

    task automatic nop(input int k);
        for (int i = 0; i < k; i++) step(C_NOP, 0, 0, 1'b0);
    endtask

    initial begin
        int op, b;
        for (int i = 0; i < 3; i++) step(C_NOP, 0, 0, 1'b1);
        nop(2);
        step(C_ACT, 1, 5, 1'b0);
        nop(5);
        step(C_WR, 1, 'h10, 1'b0);
        step(C_RD, 1, 'h10, 1'b0);
        nop(20);
        wmode = 1;
        wconst = 32'hAAAAAAAA;
        step(C_WR, 1, 'h13, 1'b0);
        nop(7);
        wconst = 32'h55555555;
        wdm0 = 4'b0101;
        step(C_WR, 1, 'h13, 1'b0);
        step(C_RD, 1, 'h13, 1'b0);
        nop(16);
        wdm0 = 4'b0000;
        step(C_ACT, 2, 7, 1'b0);
        nop(4);
        step(C_RD, 2, 0, 1'b0);
        step(C_RD, 3, 0, 1'b0);
        step(C_ACT, 2, 9, 1'b0);
        step(C_PRE, 0, 1024, 1'b0);
        step(C_MRS, 0, 3 << 4, 1'b0);
        step(C_ACT, 1, 5, 1'b0);
        nop(5);
        step(C_RD, 1, 'h10, 1'b0);
        nop(3);
        step(C_MRS, 0, 2 << 4, 1'b0);
        step(C_REF, 0, 0, 1'b0);
        nop(12);
        step(C_PRE, 0, 1024, 1'b0);
        step(C_MRS, 0, 0, 1'b0);
        step(C_ACT, 1, 5, 1'b0);
        nop(5);
        step(C_RD, 1, 'h10, 1'b0);
        nop(3);
        step(C_RD, 1, 'h18, 1'b0);
        nop(3);
        step(C_RD, 1, 'h18, 1'b0);
        nop(20);
        step(C_RD, 1, 'h10 | 1024, 1'b0);
        step(C_ACT, 1, 5, 1'b0);
        nop(5);
        step(C_RD, 1, 'h10, 1'b0);
        nop(9);
        step(C_NOP, 0, 0, 1'b1);
        step(C_NOP, 0, 0, 1'b1);
        nop(2);
        step(C_ACT, 1, 5, 1'b0);
        nop(5);
        step(C_RD, 1, 'h10, 1'b0);
        nop(14);
        wmode = 2;
        for (int k = 0; k < 600; k++) begin
            op = $urandom_range(0, 15);
            b = $urandom_range(0, 1);
            if (op < 4) step(C_ACT, b, $urandom_range(0, 3), 1'b0);
            else if (op < 8) step(C_RD, b, $urandom_range(0, 2047), 1'b0);
            else if (op < 11) step(C_WR, b, $urandom_range(0, 2047), 1'b0);
            else if (op < 13) step(C_PRE, b, $urandom_range(0, 1) * 1024, 1'b0);
            else if (op == 13) step(C_REF, 0, 0, 1'b0);
            else if (op == 14) step(C_MRS, $urandom_range(0, 2), $urandom_range(0, 127), 1'b0);
            else nop(1);
        end
        nop(30);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
